// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// Module : shift_seq_pkg
// Brief  : Opcodes, state encoding and constants shared by the shift sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_seq_pkg;

  localparam int          SHIFT_WORD_W = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic [1:0] SHIFT_OP_SLL = 2'd0;
  localparam logic [1:0] SHIFT_OP_SRL = 2'd1;
  localparam logic [1:0] SHIFT_OP_SRA = 2'd2;
  localparam logic [1:0] SHIFT_OP_RSV = 2'd3;

  typedef enum logic [1:0] {
    SHIFT_IDLE = 2'd0,
    SHIFT_RUN  = 2'd1,
    SHIFT_DONE = 2'd2
  } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_seq_step.sv
// ---------------------------------------------------------------------------
// Module : shift_seq_step
// Brief  : One partial shift of the accumulator by k (0..STEP) positions.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4,
  parameter int KW     = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [KW-1:0]     k_i,
  input  logic [1:0]        op_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] shifted_o
);

  logic [DATA_W-1:0] right_fill;

  always_comb begin
    // Vacated high bits for SRA come from the sign latched at launch, not acc's MSB.
    right_fill = sign_i ? ~({DATA_W{1'b1}} >> k_i) : {DATA_W{1'b0}};
    case (op_i)
      SHIFT_OP_SLL: shifted_o = acc_i << k_i;
      SHIFT_OP_SRL: shifted_o = acc_i >> k_i;
      SHIFT_OP_SRA: shifted_o = (acc_i >> k_i) | right_fill;
      default:      shifted_o = acc_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// Module : shift_seq
// Brief  : Multi-cycle SLL/SRL/SRA sequencer with start/ready handshake and
//          pipeline stall request.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        sa_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              stall_req_o
);

  localparam int         KW      = $clog2(STEP + 1);
  localparam logic [4:0] STEP_SA = 5'(STEP);

  shift_state_e      state_q;
  logic [DATA_W-1:0] acc_q;
  logic [4:0]        rem_q;
  logic [1:0]        op_q;
  logic              sign_q;
  logic              ready_q;
  logic [DATA_W-1:0] result_q;

  logic [KW-1:0]     step_k;
  logic [4:0]        rem_d;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    step_k = (rem_q < STEP_SA) ? rem_q[KW-1:0] : KW'(STEP);
    rem_d  = rem_q - 5'(step_k);
  end

  shift_seq_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .KW     (KW)
  ) u_step (
    .acc_i     (acc_q),
    .k_i       (step_k),
    .op_i      (op_q),
    .sign_i    (sign_q),
    .shifted_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state_q  <= SHIFT_IDLE;
      acc_q    <= DATA_W'(ZERO_WORD);
      rem_q    <= 5'd0;
      op_q     <= SHIFT_OP_SLL;
      sign_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= DATA_W'(ZERO_WORD);
    end else begin
      case (state_q)
        SHIFT_IDLE: begin
          if (start_i) begin
            acc_q  <= data_i;
            rem_q  <= sa_i;
            op_q   <= op_i;
            sign_q <= data_i[DATA_W-1];
            if (sa_i == 5'd0 || op_i == SHIFT_OP_RSV) begin
              state_q  <= SHIFT_DONE;
              ready_q  <= 1'b1;
              result_q <= (op_i == SHIFT_OP_RSV) ? DATA_W'(ZERO_WORD) : data_i;
            end else begin
              state_q <= SHIFT_RUN;
            end
          end
        end
        SHIFT_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == 5'd0) begin
            state_q  <= SHIFT_DONE;
            ready_q  <= 1'b1;
            result_q <= acc_d;
          end
        end
        SHIFT_DONE: begin
          // EX holds start_i until it has consumed the result; release ends the op.
          if (!start_i) begin
            state_q  <= SHIFT_IDLE;
            ready_q  <= 1'b0;
            result_q <= DATA_W'(ZERO_WORD);
          end
        end
        default: begin
          state_q  <= SHIFT_IDLE;
          ready_q  <= 1'b0;
          result_q <= DATA_W'(ZERO_WORD);
        end
      endcase
    end
  end

  assign stall_req_o = !annul_i &&
                       ((state_q == SHIFT_IDLE && start_i) || state_q == SHIFT_RUN);
  assign ready_o     = ready_q;
  assign result_o    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_shift_seq
// Brief  : Self-checking bench for shift_seq: directed table, random vectors,
//          annul and reset interruption sequences.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_seq;

  localparam int DATA_W = 32;
  localparam int STEP   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              annul_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] data_i;
  logic [4:0]        sa_i;
  logic [DATA_W-1:0] result_o;
  logic              ready_o;
  logic              stall_req_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  sa;
    int          hold;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t dir_tab [9];

  shift_seq #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .op_i        (op_i),
    .data_i      (data_i),
    .sa_i        (sa_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sa);
    case (op)
      2'd0:    return d << sa;
      2'd1:    return d >> sa;
      2'd2:    return 32'($signed(d) >>> sa);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [4:0] sa);
    if (op == 2'd3 || sa == 5'd0) return 1;
    return 1 + (int'(sa) + STEP - 1) / STEP;
  endfunction

  task automatic run_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa,
                           input int hold, input logic [31:0] exp_res, input int exp_lat,
                           input bit scramble, input string tag);
    int cyc;
    int stalls;
    bit got;
    @(posedge clk); #1;
    op_i = op; data_i = d; sa_i = sa; start_i = 1'b1;
    cyc = 0; stalls = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      #1;
      if (stall_req_o === 1'b1) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (scramble) begin
        data_i = $urandom; sa_i = 5'($urandom); op_i = 2'($urandom);
      end
      if (ready_o === 1'b1) got = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, " stall in done"}, 32'(stall_req_o), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, 32'(ready_o), 32'd1);
      check({tag, " hold result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, 32'(ready_o), 32'd0);
    check({tag, " release result"}, result_o, 32'h0);
  endtask

  // Launch a long SLL, then interrupt it in the third SHIFT cycle with annul or reset.
  task automatic interrupt_run(input bit use_rst, input string tag);
    @(posedge clk); #1;
    op_i = 2'd0; data_i = 32'hdead_beef; sa_i = 5'd31; start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({tag, " early ready"}, 32'(ready_o), 32'd0);
    end
    check({tag, " stall before cut"}, 32'(stall_req_o), 32'd1);
    if (use_rst) rst = 1'b1;
    else begin
      annul_i = 1'b1;
      #1;
      check({tag, " stall during annul"}, 32'(stall_req_o), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    #1;
    check({tag, " ready after cut"}, 32'(ready_o), 32'd0);
    check({tag, " result after cut"}, result_o, 32'h0);
    check({tag, " stall after cut"}, 32'(stall_req_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check({tag, " idle ready"}, 32'(ready_o), 32'd0);
    end
  endtask

  initial begin
    dir_tab[0] = '{2'd0, 32'h0404_0404, 5'd8,  0, 32'h0404_0400, 3};
    dir_tab[1] = '{2'd1, 32'h0404_0404, 5'd1,  0, 32'h0202_0202, 2};
    dir_tab[2] = '{2'd1, 32'h0404_0404, 5'd31, 0, 32'h0000_0000, 9};
    dir_tab[3] = '{2'd2, 32'h8080_0000, 5'd16, 0, 32'hffff_8080, 5};
    dir_tab[4] = '{2'd2, 32'h8080_0000, 5'd24, 0, 32'hffff_ff80, 7};
    dir_tab[5] = '{2'd2, 32'h8080_0000, 5'd31, 0, 32'hffff_ffff, 9};
    dir_tab[6] = '{2'd0, 32'h0000_1010, 5'd0,  0, 32'h0000_1010, 1};
    dir_tab[7] = '{2'd3, 32'h0000_1010, 5'd5,  0, 32'h0000_0000, 1};
    dir_tab[8] = '{2'd2, 32'h7000_0001, 5'd3,  3, 32'h0e00_0000, 2};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    op_i = 2'd0; data_i = 32'h0; sa_i = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(ready_o), 32'd0);
    check("reset result", result_o, 32'h0);
    check("reset stall", 32'(stall_req_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_shift(dir_tab[i].op, dir_tab[i].data, dir_tab[i].sa, dir_tab[i].hold,
                dir_tab[i].exp_res, dir_tab[i].exp_lat, 1'b0, $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_data;
      logic [4:0]  r_sa;
      r_op   = 2'($urandom_range(0, 3));
      r_data = $urandom;
      r_sa   = 5'($urandom_range(0, 31));
      run_shift(r_op, r_data, r_sa, $urandom_range(0, 2), ref_shift(r_op, r_data, r_sa),
                ref_latency(r_op, r_sa), 1'b1, $sformatf("rnd%0d", i));
    end

    interrupt_run(1'b0, "annul");
    interrupt_run(1'b1, "rst");
    run_shift(2'd1, 32'hf000_000f, 5'd6, 1, ref_shift(2'd1, 32'hf000_000f, 5'd6),
              ref_latency(2'd1, 5'd6), 1'b0, "recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
